// File: rtl/segre_if_prefetch.sv
// Prefetching instruction-fetch front end: one outstanding icache request at a time,
// responses buffered in a DEPTH-entry circular queue that feeds decode.
module segre_if_prefetch #(
    parameter int                 ADDR_W       = 32,
    parameter int                 INSTR_W      = 32,
    parameter int                 DEPTH        = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter bit                 BRANCH_STALL = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    output logic                         ic_req_o,
    output logic [ADDR_W-1:0]            ic_addr_o,
    input  logic                         ic_rvalid_i,
    input  logic [INSTR_W-1:0]           ic_rdata_i,
    input  logic                         ic_err_i,
    output logic                         instr_valid_o,
    output logic [INSTR_W-1:0]           instr_o,
    output logic [ADDR_W-1:0]            pc_o,
    output logic                         instr_err_o,
    input  logic                         instr_ready_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    input  logic                         branch_completed_i,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int                 PW      = $clog2(DEPTH);
    localparam int                 CW      = PW + 1;
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
    localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_BR_HOLD,
        S_ERR_HOLD,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
    logic [DEPTH-1:0]    err_mem_q;

    logic not_full, head_valid, push, pop, is_branch;

    assign not_full   = (count_q != DEPTH_C);
    assign head_valid = (count_q != '0);
    assign is_branch  = (ic_rdata_i[6:0] == 7'b1100011) ||
                        (ic_rdata_i[6:0] == 7'b1101111) ||
                        (ic_rdata_i[6:0] == 7'b1100111);

    // Decode handshake: the head transfers on a cycle where instr_valid_o and
    // instr_ready_i are both high; valid never depends on ready.
    assign push = (state_q == S_WAIT) && ic_rvalid_i && !redirect_i;
    assign pop  = head_valid && instr_ready_i && !redirect_i;

    // Masked during reset because the reset state is REQ with an empty queue.
    assign ic_req_o  = (state_q == S_REQ) && not_full && !rsn_i;
    assign ic_addr_o = fetch_pc_q;

    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
    assign pc_o          = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign instr_err_o   = head_valid & err_mem_q[rd_ptr_q];
    assign count_o       = count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            // A response still in flight belongs to the old stream and must be eaten.
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !ic_rvalid_i) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (not_full) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (ic_rvalid_i) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        if (ic_err_i)                      state_d = S_ERR_HOLD;
                        else if (BRANCH_STALL && is_branch) state_d = S_BR_HOLD;
                        else                               state_d = S_REQ;
                    end
                end
                S_BR_HOLD: begin
                    if (branch_completed_i) state_d = S_REQ;
                end
                S_ERR_HOLD: state_d = S_ERR_HOLD;
                S_DRAIN: begin
                    if (ic_rvalid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by a non-zero count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= ic_rdata_i;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            err_mem_q[wr_ptr_q]   <= ic_err_i;
        end
    end

endmodule

// File: tb/tb_segre_if_prefetch.sv
// Directed bench for segre_if_prefetch: a small icache model answers requests and
// each scenario checks hand-computed request addresses, queue heads and counts.
module tb_segre_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_rvalid, ic_err;
    logic [31:0] ic_rdata;
    logic        ready, redirect, bc;
    logic [31:0] redirect_pc;

    logic        ic_req_o, instr_valid_o, instr_err_o;
    logic [31:0] ic_addr_o, instr_o, pc_o;
    logic [2:0]  count_o;

    logic        nb_req, nb_valid, nb_err;
    logic [31:0] nb_addr, nb_instr, nb_pc;
    logic [2:0]  nb_count;

    int checks = 0;
    int errors = 0;
    int nreq;

    // icache model state
    logic        pend_req, outst;
    logic [31:0] pend_addr, o_addr, jal_addr, err_addr;
    int          wait_cnt, extra_lat;

    always #5 clk = ~clk;

    segre_if_prefetch dut (
        .clk_i(clk), .rsn_i(rst),
        .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o),
        .ic_rvalid_i(ic_rvalid), .ic_rdata_i(ic_rdata), .ic_err_i(ic_err),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .instr_err_o(instr_err_o), .instr_ready_i(ready),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .branch_completed_i(bc), .count_o(count_o)
    );

    // Same inputs as dut; only compared up to the first branch, where the policies diverge.
    segre_if_prefetch #(.BRANCH_STALL(1'b0)) dut_nb (
        .clk_i(clk), .rsn_i(rst),
        .ic_req_o(nb_req), .ic_addr_o(nb_addr),
        .ic_rvalid_i(ic_rvalid), .ic_rdata_i(ic_rdata), .ic_err_i(ic_err),
        .instr_valid_o(nb_valid), .instr_o(nb_instr), .pc_o(nb_pc),
        .instr_err_o(nb_err), .instr_ready_i(ready),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .branch_completed_i(bc), .count_o(nb_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == jal_addr) return 32'h0000_006F;
        return {a[11:0], 20'h00013};
    endfunction

    // Request sampled at the edge, response driven 1+extra_lat cycles later.
    always @(posedge clk) begin
        pend_req  = ic_req_o;
        pend_addr = ic_addr_o;
        #1;
        ic_rvalid = 1'b0;
        ic_err    = 1'b0;
        if (rst) begin
            outst = 1'b0;
        end else begin
            if (pend_req) begin
                outst    = 1'b1;
                o_addr   = pend_addr;
                wait_cnt = extra_lat;
            end
            if (outst) begin
                if (wait_cnt == 0) begin
                    ic_rvalid = 1'b1;
                    ic_rdata  = mem_word(o_addr);
                    ic_err    = (o_addr == err_addr);
                    outst     = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0; bc = 1'b0;
        ic_rvalid = 1'b0; ic_rdata = '0; ic_err = 1'b0;
        pend_req = 1'b0; pend_addr = '0; outst = 1'b0; o_addr = '0;
        wait_cnt = 0; extra_lat = 0;
        jal_addr = 32'hFFFF_FFFF; err_addr = 32'hFFFF_FFFF;

        repeat (2) step();
        check("rst_req",   ic_req_o, 0);
        check("rst_addr",  ic_addr_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc",    pc_o, 0);
        check("rst_err",   instr_err_o, 0);
        check("rst_count", count_o, 0);

        // sequential fetch, one instruction per 2 cycles
        do_reset();
        ready = 1'b1;
        check("seq_req0",  ic_req_o, 1);
        check("seq_addr0", ic_addr_o, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i % 2 == 0) begin
                check("seq_valid", instr_valid_o, 1);
                check("seq_pc",    pc_o, 32'((i - 2) * 2));
                check("seq_instr", instr_o, {12'((i - 2) * 2), 20'h00013});
                check("seq_req",   ic_req_o, 1);
                check("seq_addr",  ic_addr_o, 32'(i * 2));
            end else begin
                check("seq_gap_valid", instr_valid_o, 0);
                check("seq_gap_req",   ic_req_o, 0);
            end
        end

        // backpressure: exactly DEPTH requests, then one per pop
        do_reset();
        ready = 1'b0;
        nreq = int'(ic_req_o);
        for (int i = 1; i <= 15; i++) begin
            step();
            nreq += int'(ic_req_o);
        end
        check("bp_nreq",  nreq, 4);
        check("bp_count", count_o, 4);
        check("bp_req",   ic_req_o, 0);
        check("bp_pc",    pc_o, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("bp_pop_count", count_o, 3);
        check("bp_pop_pc",    pc_o, 32'h4);
        check("bp_pop_addr",  ic_addr_o, 32'h10);
        nreq = int'(ic_req_o);
        for (int i = 1; i <= 9; i++) begin
            step();
            nreq += int'(ic_req_o);
        end
        check("bp_nreq2",  nreq, 1);
        check("bp_count2", count_o, 4);

        // branch stall on JAL at 0x8
        do_reset();
        jal_addr = 32'h8;
        ready = 1'b1;
        repeat (6) step();
        check("br_valid",   instr_valid_o, 1);
        check("br_pc",      pc_o, 32'h8);
        check("br_instr",   instr_o, 32'h0000_006F);
        check("br_req",     ic_req_o, 0);
        check("br_addr",    ic_addr_o, 32'hC);
        check("nb_br_req",  nb_req, 1);
        check("nb_br_addr", nb_addr, 32'hC);
        nreq = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            nreq += int'(ic_req_o);
        end
        check("br_hold_nreq",  nreq, 0);
        check("br_hold_valid", instr_valid_o, 0);
        bc = 1'b1;
        step();
        bc = 1'b0;
        check("br_rel_req",  ic_req_o, 1);
        check("br_rel_addr", ic_addr_o, 32'hC);
        jal_addr = 32'hFFFF_FFFF;

        // redirect while a response is outstanding
        do_reset();
        ready = 1'b0;
        repeat (4) step();
        check("rd_pre_count", count_o, 2);
        check("rd_pre_addr",  ic_addr_o, 32'h8);
        extra_lat = 2;
        step();
        check("rd_wait_req", ic_req_o, 0);
        check("rd_wait_pc",  pc_o, 0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        extra_lat = 0;
        check("rd_flush_count", count_o, 0);
        check("rd_flush_valid", instr_valid_o, 0);
        check("rd_flush_instr", instr_o, 32'h0000_0013);
        check("rd_flush_req",   ic_req_o, 0);
        check("rd_flush_addr",  ic_addr_o, 32'h100);
        step();
        check("rd_drain_req",   ic_req_o, 0);
        check("rd_drain_count", count_o, 0);
        step();
        check("rd_late_count", count_o, 0);
        check("rd_new_req",    ic_req_o, 1);
        check("rd_new_addr",   ic_addr_o, 32'h100);
        repeat (2) step();
        check("rd_new_valid", instr_valid_o, 1);
        check("rd_new_pc",    pc_o, 32'h100);
        check("rd_new_instr", instr_o, 32'h1000_0013);

        // fetch fault at 0x10
        do_reset();
        err_addr = 32'h10;
        ready = 1'b1;
        repeat (10) step();
        check("flt_valid", instr_valid_o, 1);
        check("flt_pc",    pc_o, 32'h10);
        check("flt_err",   instr_err_o, 1);
        check("flt_req",   ic_req_o, 0);
        nreq = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            nreq += int'(ic_req_o);
        end
        check("flt_hold_nreq", nreq, 0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("flt_rd_req",   ic_req_o, 1);
        check("flt_rd_addr",  ic_addr_o, 32'h200);
        check("flt_rd_valid", instr_valid_o, 0);
        repeat (2) step();
        check("flt_new_pc",  pc_o, 32'h200);
        check("flt_new_err", instr_err_o, 0);
        err_addr = 32'hFFFF_FFFF;

        // simultaneous push and pop at count 2, across pointer wrap
        do_reset();
        ready = 1'b0;
        repeat (4) step();
        check("pp_fill_count", count_o, 2);
        check("pp_fill_pc",    pc_o, 0);
        step();
        ready = 1'b1;
        for (int k = 3; k <= 7; k++) begin
            step();
            ready = 1'b0;
            check("pp_count", count_o, 2);
            check("pp_pc",    pc_o, 32'((k - 2) * 4));
            step();
            ready = 1'b1;
        end
        ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segre_if_prefetch.md
# segre_if_prefetch

Parametrised instruction-fetch front end that replaces the single-entry fetch stage with a prefetching unit. It issues sequential fetches to the instruction cache/TLB path and buffers responses in a DEPTH-entry instruction queue. It hands instructions to decode over a valid/ready handshake and supports a compile-time branch policy: stall fetch on control-flow opcodes, or keep fetching sequentially and flush on redirect. It sits between the icache and the ID stage.

## Interface

**Parameters**
- ADDR_W, 32, fetch address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, instruction queue entries; power of two, ≥2.
- RESET_PC, 0, fetch address after reset.
- BRANCH_STALL, 1, selects the branch policy.
  - 1: after fetching a BRANCH/JAL/JALR (opcode 1100011/1101111/1100111), stop fetching until `branch_completed_i` or `redirect_i`.
  - 0: never stall on branches.

**Ports**
- `clk_i`, in, 1: clock.
- `rsn_i`, in, 1: reset, asynchronous, active-high.
- `ic_req_o`, out, 1: single-cycle fetch request pulse.
- `ic_addr_o`, out, ADDR_W: fetch address; valid when `ic_req_o` = 1.
- `ic_rvalid_i`, in, 1: response valid. Arrives ≥1 cycle after the request; only one request is outstanding at a time.
- `ic_rdata_i`, in, INSTR_W: fetched instruction.
- `ic_err_i`, in, 1: fetch fault (e.g. ITLB miss); qualified by `ic_rvalid_i`.
- `instr_valid_o`, out, 1: queue head is valid.
- `instr_o`, out, INSTR_W: head instruction; NOP (0x00000013) when not valid.
- `pc_o`, out, ADDR_W: head instruction PC.
- `instr_err_o`, out, 1: head entry carries a fetch fault.
- `instr_ready_i`, in, 1: decode accepts the head; a pop occurs when valid & ready.
- `redirect_i`, in, 1: flush the queue and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`, in, ADDR_W: new fetch PC.
- `branch_completed_i`, in, 1: releases the branch stall.
- `count_o`, out, $clog2(DEPTH)+1: queue occupancy.

## Operation

**Registered state**
- `fetch_pc`
- FSM state: REQ, WAIT, BR_HOLD, ERR_HOLD, DRAIN
- Circular queue with read/write pointers and a count.

**FSM**
- **REQ:** if `count_o` < DEPTH, drive `ic_req_o` = 1 with `ic_addr_o` = `fetch_pc`, then go to WAIT. Otherwise hold with `ic_req_o` = 0.
- **WAIT:** on `ic_rvalid_i`:
  - push {rdata, `fetch_pc`, err} and set `fetch_pc` += 4 (modulo 2^ADDR_W);
  - if err, go to ERR_HOLD;
  - else if BRANCH_STALL and the opcode is a branch, go to BR_HOLD;
  - else go to REQ.
- **BR_HOLD:** on `branch_completed_i`, go to REQ; `fetch_pc` is unchanged.
- **ERR_HOLD:** no fetching; leave only on `redirect_i`.
- **DRAIN:** the outstanding response belongs to a flushed stream. Discard the next `ic_rvalid_i` (no push), then go to REQ.

**Redirect** (highest priority, any state)
- Clear the queue (count = 0, pointers = 0) and set `fetch_pc` = `redirect_pc_i`.
- Next state is DRAIN if a response is still outstanding: in WAIT with `ic_rvalid_i` = 0, or in DRAIN with `ic_rvalid_i` = 0. Otherwise next state is REQ.
- A response arriving in the redirect cycle is dropped.
- A pop in the redirect cycle has no effect beyond the flush.
- `redirect_i` together with `branch_completed_i` behaves as `redirect_i` alone.

**Queue**
- Push and pop in the same cycle leave the count unchanged.
- Push never occurs when full, because a request is issued only when count < DEPTH and only one is outstanding.
- Pop when empty is ignored.
- Pointers wrap modulo DEPTH.

## Timing

**Reset values**
- `ic_req_o` = 0, `ic_addr_o` = RESET_PC, `instr_valid_o` = 0, `instr_o` = NOP, `pc_o` = 0, `instr_err_o` = 0, `count_o` = 0.
- State = REQ, `fetch_pc` = RESET_PC.
- Reset mid-operation discards any outstanding response. The response may still arrive after reset and must be ignored if it arrives while the state is REQ, because it is unrequested.

**Latencies**
- First `ic_req_o` occurs in the first cycle after reset deasserts.
- Response in cycle t: `instr_valid_o` in cycle t+1 (no bypass); the next `ic_req_o` in cycle t+1 if the queue has space.
- Redirect in cycle t with nothing outstanding: `ic_req_o` to `redirect_pc_i` in cycle t+1, and `instr_valid_o` = 0 in cycle t+1.
- Redirect in cycle t with a response outstanding: after draining, the request goes out the cycle after the discarded response.
- Steady-state throughput with 1-cycle icache latency: one instruction per 2 cycles.
- `count_o`, `instr_*` and `ic_*` outputs are all registered or derived from registered state only.

## Test plan

1. **Sequential fetch.** Reset, 1-cycle icache returning ADDI words, `instr_ready_i` = 1.
   - Requests at 0x0, 0x4, 0x8, ….
   - `pc_o` sequence 0x0, 0x4, …, one instruction per 2 cycles.
2. **Backpressure.** `instr_ready_i` = 0, DEPTH = 4.
   - Exactly 4 requests issued, then `count_o` = 4 and `ic_req_o` stays 0.
   - After one pop, exactly one new request.
3. **Branch stall.** Fetch 0x0000006F (JAL) at 0x8 with BRANCH_STALL = 1.
   - No request after 0xC is computed, until `branch_completed_i`.
   - Then a request to 0xC.
   - With BRANCH_STALL = 0, a request to 0xC follows immediately.
4. **Redirect with a response outstanding.** Assert redirect to 0x100 during WAIT.
   - Queue empties and the late response is not pushed.
   - Next request is to 0x100 and `pc_o` = 0x100.
5. **Fault.** `ic_err_i` = 1 on the response for 0x10.
   - Entry with `instr_err_o` = 1 and `pc_o` = 0x10.
   - No further requests until redirect to 0x200, which restarts fetching at 0x200.
6. **Simultaneous push and pop** at `count_o` = 2: count stays 2; `pc_o` order is preserved across pointer wrap.
